// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad digit capture slice: scan FSM
// states, the physical key layout and the column drive reset value.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } scan_state_t;

  // Key codes indexed as KEY_MAP[row][col]
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  localparam logic [3:0] COLS_RESET = 4'b1110;

  // Index of the lowest-numbered active-low row; only meaningful when some row is low
  function automatic logic [1:0] lowest_low_row(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    if (!r[3]) idx = 2'd3;
    if (!r[2]) idx = 2'd2;
    if (!r[1]) idx = 2'd1;
    if (!r[0]) idx = 2'd0;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad rows. Synchronous
// active-low reset parks both stages at all-ones (no key pressed).
module keypad_row_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Shift the raw rows through two flops so downstream logic sees a settled value
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_digit_capture.sv
// 4x4 keypad scanner with debounce that keeps the last two decoded digits.
// new_digit drives onboard_sw and old_digit drives bboard_sw downstream.
// Optional macro KEY_STROBE_EN adds a one-cycle key_strobe on each capture.
module keypad_digit_capture
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 6000,
  parameter int DB_TICKS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] new_digit,
  output logic [3:0] old_digit
`ifdef KEY_STROBE_EN
  ,
  output logic       key_strobe
`endif
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DB_TICKS);

  logic [3:0]       rows_sync;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  scan_state_t      state, state_next;
  logic [1:0]       col, col_next;
  logic [1:0]       row_sel, row_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             capture;
  logic             db_done;

  keypad_row_sync #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows),
    .q     (rows_sync)
  );

  assign tick    = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign db_done = (cnt == CNT_W'(DB_TICKS - 2));

  // Free-running divider producing the scan tick
  always_ff @(posedge clk) begin
    if (!reset) div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else div_cnt <= div_cnt + DIV_W'(1);
  end

  // State, column, latched row, debounce counter and column drive registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= SCAN;
      col     <= 2'd0;
      row_sel <= 2'd0;
      cnt     <= '0;
      cols    <= COLS_RESET;
    end else begin
      state   <= state_next;
      col     <= col_next;
      row_sel <= row_next;
      cnt     <= cnt_next;
      cols    <= ~(4'b0001 << col_next);
    end
  end

  // Scan/debounce decisions, taken only on tick cycles
  always_comb begin
    state_next = state;
    col_next   = col;
    row_next   = row_sel;
    cnt_next   = cnt;
    capture    = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (rows_sync != 4'b1111) begin
            row_next   = lowest_low_row(rows_sync);
            cnt_next   = '0;
            state_next = PRESS_DB;
          end else begin
            col_next = col + 2'd1;
          end
        end
        PRESS_DB: begin
          if (!rows_sync[row_sel]) begin
            cnt_next = cnt + CNT_W'(1);
            if (db_done) begin
              capture    = 1'b1;
              state_next = HELD;
            end
          end else begin
            state_next = SCAN;
            col_next   = col + 2'd1;
          end
        end
        HELD: begin
          if (rows_sync[row_sel]) begin
            cnt_next   = '0;
            state_next = REL_DB;
          end
        end
        REL_DB: begin
          if (rows_sync[row_sel]) begin
            cnt_next = cnt + CNT_W'(1);
            if (db_done) begin
              state_next = SCAN;
              col_next   = col + 2'd1;
            end
          end else begin
            state_next = HELD;
          end
        end
        default: state_next = SCAN;
      endcase
    end
  end

  // Digit history shifts once per confirmed press
  always_ff @(posedge clk) begin
    if (!reset) begin
      new_digit <= 4'h0;
      old_digit <= 4'h0;
    end else if (capture) begin
      old_digit <= new_digit;
      new_digit <= KEY_MAP[row_sel][col];
    end
  end

`ifdef KEY_STROBE_EN
  // Strobe rises on the same edge the digits update
  always_ff @(posedge clk) begin
    if (!reset) key_strobe <= 1'b0;
    else key_strobe <= capture;
  end
`endif

endmodule

// File: tb/tb_keypad_digit_capture.sv
// Bench for keypad_digit_capture: a simulated keypad matrix driven by the
// DUT column outputs, a behavioural model checked every cycle, and directed
// presses with hand-computed digit expectations.
module tb_keypad_digit_capture;

  localparam int SCAN_DIV = 4;
  localparam int DB_TICKS = 3;
  localparam logic [63:0] LAYOUT = 64'h123A_456B_789C_E0FD;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] new_digit;
  logic [3:0] old_digit;
`ifdef KEY_STROBE_EN
  logic       key_strobe;
`endif

  logic [15:0] keys_down = 16'h0;
  bit          checking = 1'b0;
  int          check_count = 0;
  int          pass_count = 0;

  int          m_col, m_row, m_phase, m_stable, m_cyc;
  logic [3:0]  m_new, m_old, syn1, syn2, seen;
  bit          m_strobe;

  keypad_digit_capture #(.SCAN_DIV(SCAN_DIV), .DB_TICKS(DB_TICKS)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .new_digit (new_digit),
    .old_digit (old_digit)
`ifdef KEY_STROBE_EN
    ,
    .key_strobe(key_strobe)
`endif
  );

  always #5 clk = ~clk;

  // Key code printed at matrix position r*4+c
  function automatic logic [3:0] keyAt(input int pos);
    logic [63:0] m;
    m = LAYOUT;
    return m[63 - 4*pos -: 4];
  endfunction

  function automatic int posOf(input logic [3:0] k);
    for (int i = 0; i < 16; i++) if (keyAt(i) == k) return i;
    return 0;
  endfunction

  // Physical matrix: a row reads low when a pressed key joins it to a driven column
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_down[r*4+c] && (cols[c] === 1'b0)) rows[r] = 1'b0;
  end

  // Behavioural model: counts stable ticks directly and tracks a scan phase
  always @(posedge clk) begin
    m_strobe = 1'b0;
    if (!reset) begin
      m_col = 0; m_row = 0; m_phase = 0; m_stable = 0; m_cyc = 0;
      m_new = 4'h0; m_old = 4'h0; syn1 = 4'hF; syn2 = 4'hF;
    end else begin
      seen = syn2;
      if ((m_cyc % SCAN_DIV) == SCAN_DIV - 1) begin
        case (m_phase)
          0: if (seen != 4'hF) begin
               for (int r = 3; r >= 0; r--) if (!seen[r]) m_row = r;
               m_stable = 1; m_phase = 1;
             end else m_col = (m_col + 1) % 4;
          1: if (!seen[m_row]) begin
               m_stable++;
               if (m_stable == DB_TICKS) begin
                 m_old = m_new; m_new = keyAt(m_row*4 + m_col);
                 m_phase = 2; m_strobe = 1'b1;
               end
             end else begin m_phase = 0; m_col = (m_col + 1) % 4; end
          2: if (seen[m_row]) begin m_stable = 1; m_phase = 3; end
          default: if (seen[m_row]) begin
               m_stable++;
               if (m_stable == DB_TICKS) begin m_phase = 0; m_col = (m_col + 1) % 4; end
             end else m_phase = 2;
        endcase
      end
      m_cyc++;
      syn2 = syn1;
      syn1 = rows;
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
  endtask

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("model_cols", cols, 4'hF ^ (4'h1 << m_col));
      checkOutput("model_new", new_digit, m_new);
      checkOutput("model_old", old_digit, m_old);
`ifdef KEY_STROBE_EN
      checkOutput("model_strobe", {3'b0, key_strobe}, {3'b0, m_strobe});
`endif
    end
  end

  task automatic applyStimulus(input logic [3:0] key, input bit down, input int ticks);
    keys_down[posOf(key)] = down;
    repeat (ticks * SCAN_DIV) @(negedge clk);
  endtask

  task automatic waitCols(input logic [3:0] target, input bit equal);
    int n;
    n = 0;
    while (((cols == target) != equal) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      check_count++;
      $display("[TB] FAIL wait_cols: got %b expected %b", cols, target);
    end
  endtask

  logic [3:0] rot [4];

  initial begin
    rot[0] = 4'b1101; rot[1] = 4'b1011; rot[2] = 4'b0111; rot[3] = 4'b1110;
    $display("[TB] start");
    repeat (2) @(negedge clk);
    checking = 1'b1;
    checkOutput("reset_cols", cols, 4'b1110);
    checkOutput("reset_new", new_digit, 4'h0);
    checkOutput("reset_old", old_digit, 4'h0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (SCAN_DIV) @(negedge clk);
      checkOutput("rotate", cols, rot[i]);
    end

    $display("[TB] hold key 5");
    applyStimulus(4'h5, 1'b1, 10);
    checkOutput("k5_new", new_digit, 4'h5);
    checkOutput("k5_old", old_digit, 4'h0);
    applyStimulus(4'h5, 1'b0, 8);

    $display("[TB] repeat 5, then A, then 0");
    applyStimulus(4'h5, 1'b1, 10);
    checkOutput("k55_new", new_digit, 4'h5);
    checkOutput("k55_old", old_digit, 4'h5);
    applyStimulus(4'h5, 1'b0, 8);
    applyStimulus(4'hA, 1'b1, 10);
    checkOutput("kA_new", new_digit, 4'hA);
    checkOutput("kA_old", old_digit, 4'h5);
    applyStimulus(4'hA, 1'b0, 8);
    applyStimulus(4'h0, 1'b1, 10);
    checkOutput("k0_new", new_digit, 4'h0);
    checkOutput("k0_old", old_digit, 4'hA);
    applyStimulus(4'h0, 1'b0, 8);

    $display("[TB] bounce on key 1");
    waitCols(4'b1110, 1'b0);
    waitCols(4'b1110, 1'b1);
    keys_down[posOf(4'h1)] = 1'b1;
    repeat (4) @(negedge clk);
    keys_down[posOf(4'h1)] = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("bounce_cols", cols, 4'b1101);
    checkOutput("bounce_new", new_digit, 4'h0);
    checkOutput("bounce_old", old_digit, 4'hA);
    applyStimulus(4'h1, 1'b0, 4);

    $display("[TB] hold 2, add 3, release 2");
    applyStimulus(4'h2, 1'b1, 10);
    checkOutput("k2_new", new_digit, 4'h2);
    checkOutput("k2_old", old_digit, 4'h0);
    applyStimulus(4'h3, 1'b1, 4);
    checkOutput("k3_ignored", new_digit, 4'h2);
    applyStimulus(4'h2, 1'b0, 12);
    checkOutput("k3_new", new_digit, 4'h3);
    checkOutput("k3_old", old_digit, 4'h2);
    applyStimulus(4'h3, 1'b0, 8);

    $display("[TB] reset while holding 9");
    applyStimulus(4'h9, 1'b1, 10);
    checkOutput("k9_new", new_digit, 4'h9);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst9_cols", cols, 4'b1110);
    checkOutput("rst9_new", new_digit, 4'h0);
    checkOutput("rst9_old", old_digit, 4'h0);
    reset = 1'b1;
    repeat (12 * SCAN_DIV) @(negedge clk);
    checkOutput("k9_again_new", new_digit, 4'h9);
    checkOutput("k9_again_old", old_digit, 4'h0);
    applyStimulus(4'h9, 1'b0, 8);

    checking = 1'b0;
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/keypad_digit_capture.md
Name: keypad_digit_capture

Overview:
- Scans a 4x4 matrix keypad, synchronizes and debounces the row inputs, and decodes each confirmed key press to a hex digit.
- Keeps the two most recent digits: new_digit is the latest key, old_digit is the one before it.
- Sits directly upstream of the seven-segment select/multiplex stage: new_digit feeds onboard_sw and old_digit feeds bboard_sw.

Parameters:
- SCAN_DIV, 6000, clk cycles per scan tick (1 kHz at 6 MHz); must be >= 4.
- DB_TICKS, 20, consecutive stable scan ticks needed to accept a press or a release; must be >= 2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low
- rows  input  4  keypad rows, active-low, asynchronous
- cols  output  4  keypad column drive, one-cold (exactly one bit low)
- new_digit  output  4  most recent accepted key code
- old_digit  output  4  previously accepted key code

Behaviour:
- Reset: reset, synchronous, active-low; clock clk. A low reset on a clk edge forces the following, from any state, including mid-debounce:
  - cols=4'b1110, new_digit=4'h0, old_digit=4'h0
  - state=SCAN, tick divider=0, debounce counter=0
  - row synchronizer=4'b1111
- Rows pass through a 2-flop synchronizer (2-cycle latency). All decisions use the synchronized rows only.
- Scan tick: a one-cycle pulse every SCAN_DIV cycles from a free-running divider. All state transitions below occur only on tick cycles.
- Column index c is in 0..3; cols = ~(1<<c).
- Key map, rows r0..r3 by cols c0..c3:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- FSM states: SCAN, PRESS_DB, HELD, REL_DB.
- SCAN:
  - If any synced row is low, latch r = the lowest-index low row, keep c, clear cnt, go to PRESS_DB.
  - Otherwise advance c to (c+1) mod 4.
- PRESS_DB (column frozen):
  - Row r low: cnt++. When cnt reaches DB_TICKS-1, capture and go to HELD.
  - Row r high: the press is a bounce. Return to SCAN, advance c, no capture.
- Capture: old_digit<=new_digit and new_digit<=map(r,c), in the same clk edge as the transition to HELD. Exactly one capture per press.
- HELD (column frozen): row r high -> clear cnt, go to REL_DB. Other keys are ignored.
- REL_DB:
  - Row r high: cnt++. When cnt reaches DB_TICKS-1, go to SCAN and advance c.
  - Row r low: return to HELD, no new capture.
- Boundary conditions:
  - A second key pressed while a key is held is ignored. It is captured only after the first key's release is debounced and the scan reaches it.
  - Repeated presses of the same key each produce a capture (new_digit=old_digit is legal).
  - The digit outputs are registered and change only on a capture.

Optional Feature:
- Macro KEY_STROBE_EN.
- Defined: adds output key_strobe (1 bit, reset 0), high for exactly one clk cycle coincident with the capture edge, so the digits are already updated in the same cycle the strobe is high.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package keypad_pkg holds:
  - scan_state_t enum {SCAN, PRESS_DB, HELD, REL_DB}
  - 4x4 KEY_MAP constant array of logic [3:0]
  - COLS_RESET=4'b1110
- One sub-module, keypad_row_sync: parameterized-width 2-flop synchronizer with synchronous active-low reset to all-ones.
- The FSM, divider, debounce counter and digit registers stay in keypad_digit_capture.

Test Plan (SCAN_DIV=4, DB_TICKS=3):
1. Assert reset for 2 cycles, rows=1111 -> cols=1110, new=0, old=0. Cols then rotate 1110->1101->1011->0111->1110, one step per 4 clks.
2. Hold key 5 (row1 low while col1 driven) for 10 ticks -> new=5, old=0. Capture occurs exactly once; after release, scanning resumes from col2.
3. Press/release 5, then press A -> new=A, old=5. Then press 0 -> new=0, old=A.
4. Bounce: row0 low for 1 tick in col0, then high -> no capture, digits unchanged, state returns to SCAN and c advances to col1.
5. Hold 2, then also press 3; release 2, keep 3 held -> first capture new=2. After the release debounce and the scan reaching col2, second capture new=3, old=2.
6. Reset pulse while HELD on key 9 with new=9 -> next edge: cols=1110, new=0, old=0, state SCAN. With 9 still held, it is recaptured after re-scan and debounce.
